// File: rtl/det_bist_pkg.sv
// det_bist_pkg
// Shared definitions for the detector BIST controller:
//   bist_state_t  - controller state encoding
//   INIT_CYCLES   - number of cycles the detector is held in reset before stimulus
package det_bist_pkg;

    localparam int INIT_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_t;

endpackage

// File: rtl/det_bist_shreg.sv
// det_bist_shreg
// Parallel-in / serial-out shift register used to serialise the stimulus
// pattern, LSB first.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture din (has priority over shift)
//   shift    : move every bit one place towards bit 0, zero-filling the MSB
//   din      : parallel load value
//   q        : current LSB (next serial bit)
module det_bist_shreg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         q
);

    logic [W-1:0] data_reg;
    logic [W-1:0] data_next;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            if (gi == W - 1) begin : g_top
                assign data_next[gi] = load ? din[gi] : (shift ? 1'b0 : data_reg[gi]);
            end else begin : g_mid
                assign data_next[gi] = load ? din[gi] : (shift ? data_reg[gi+1] : data_reg[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
        end else begin
            data_reg <= data_next;
        end
    end

    assign q = data_reg[0];

endmodule

// File: rtl/det_bist_ctrl.sv
// det_bist_ctrl
// Built-in self test controller for a serial pattern detector. On start it
// resets the detector, drives len pattern bits (LSB first) into it, counts
// the cycles on which the detector reports a match and pulses done.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : run request (only honoured in IDLE)
//   pattern    : stimulus bits, captured on start
//   len        : number of bits to drive, 0 or >PAT_W means PAT_W
//   det_out    : detector output under test
//   abort      : (only when DET_BIST_ABORT_EN is defined) cancel a running test
//   det_in     : serial stimulus to the detector
//   det_rstn   : active-low detector reset
//   busy       : run in progress (INIT, SHIFT, DRAIN)
//   done       : one-cycle completion pulse
//   match_cnt  : number of det_out=1 samples in the last run
// Optional feature macro: DET_BIST_ABORT_EN adds the abort input.
module det_bist_ctrl
    import det_bist_pkg::*;
#(
    parameter int PAT_W = 16,
    parameter int LEN_W = $clog2(PAT_W) + 1,
    parameter int CNT_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             det_out,
`ifdef DET_BIST_ABORT_EN
    input  logic             abort,
`endif
    output logic             det_in,
    output logic             det_rstn,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] INIT_LAST = LEN_W'(INIT_CYCLES - 1);

    bist_state_t      state_reg;
    logic [LEN_W-1:0] cyc_reg;
    logic [LEN_W-1:0] len_reg;
    logic [CNT_W-1:0] match_cnt_reg;
    logic             det_in_reg;
    logic             det_rstn_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [LEN_W-1:0] len_clamped;
    logic             sh_load;
    logic             sh_shift;
    logic             sh_q;
    logic             abort_hit;
    logic             shift_last;

    always_comb begin
        len_clamped = len;
        if (len == '0 || len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    assign shift_last = (cyc_reg == len_reg - LEN_W'(1));

`ifdef DET_BIST_ABORT_EN
    assign abort_hit = abort && (state_reg == ST_INIT || state_reg == ST_SHIFT ||
                                 state_reg == ST_DRAIN);
`else
    assign abort_hit = 1'b0;
`endif

    // The shifter LSB always holds the bit that goes out on the next SHIFT
    // cycle: it advances when leaving INIT and on every non-final SHIFT cycle.
    assign sh_load  = (state_reg == ST_IDLE) && start;
    assign sh_shift = ((state_reg == ST_INIT) && (cyc_reg == INIT_LAST)) ||
                      ((state_reg == ST_SHIFT) && !shift_last);

    det_bist_shreg #(
        .W (PAT_W)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (pattern),
        .q     (sh_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cyc_reg       <= '0;
            len_reg       <= '0;
            match_cnt_reg <= '0;
            det_in_reg    <= 1'b0;
            det_rstn_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (abort_hit) begin
                // Partial match count is deliberately kept
                state_reg    <= ST_IDLE;
                cyc_reg      <= '0;
                det_in_reg   <= 1'b0;
                det_rstn_reg <= 1'b1;
                busy_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        det_in_reg <= 1'b0;
                        busy_reg   <= 1'b0;
                        if (start) begin
                            state_reg     <= ST_INIT;
                            len_reg       <= len_clamped;
                            match_cnt_reg <= '0;
                            cyc_reg       <= '0;
                            det_rstn_reg  <= 1'b0;
                            busy_reg      <= 1'b1;
                        end else begin
                            det_rstn_reg  <= 1'b1;
                        end
                    end
                    ST_INIT: begin
                        if (cyc_reg == INIT_LAST) begin
                            state_reg    <= ST_SHIFT;
                            cyc_reg      <= '0;
                            det_in_reg   <= sh_q;
                            det_rstn_reg <= 1'b1;
                        end else begin
                            cyc_reg <= cyc_reg + LEN_W'(1);
                        end
                    end
                    ST_SHIFT: begin
                        // Detector output lags det_in by one cycle, so the
                        // first SHIFT cycle carries no valid sample.
                        if (cyc_reg != '0) begin
                            match_cnt_reg <= match_cnt_reg + CNT_W'(det_out);
                        end
                        if (shift_last) begin
                            state_reg  <= ST_DRAIN;
                            det_in_reg <= 1'b0;
                        end else begin
                            cyc_reg    <= cyc_reg + LEN_W'(1);
                            det_in_reg <= sh_q;
                        end
                    end
                    ST_DRAIN: begin
                        // Collects the response to the final stimulus bit
                        match_cnt_reg <= match_cnt_reg + CNT_W'(det_out);
                        state_reg     <= ST_DONE;
                        det_in_reg    <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end
                    ST_DONE: begin
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg    <= ST_IDLE;
                        cyc_reg      <= '0;
                        det_in_reg   <= 1'b0;
                        det_rstn_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign det_in    = det_in_reg;
    assign det_rstn  = det_rstn_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign match_cnt = match_cnt_reg;

endmodule
